// File: rtl/stack_cpu.sv
// stack_cpu: multi-cycle stack machine; instructions from a synchronous ROM, operand stack in a synchronous RAM.
// Define STACK_CPU_BOUNDS_EN to trap stack overflow/underflow in DECODE (otherwise sp wraps modulo STACK_DEPTH).
module stack_cpu #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int MEM_LAT     = 2,
  parameter int STACK_BASE  = 0,
  parameter int STACK_DEPTH = 256
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] seg1,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] sp_out,
  output logic [3:0]        state_out,
  output logic              halted,
  output logic              error
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  localparam logic [15:0] OP_NOP  = 16'h0000;
  localparam logic [15:0] OP_IMM  = 16'h0002;
  localparam logic [15:0] OP_JMP  = 16'h1000;
  localparam logic [15:0] OP_JZ   = 16'h1001;
  localparam logic [15:0] OP_ADD  = 16'h2000;
  localparam logic [15:0] OP_SUB  = 16'h2001;
  localparam logic [15:0] OP_AND  = 16'h2002;
  localparam logic [15:0] OP_OR   = 16'h2003;
  localparam logic [15:0] OP_XOR  = 16'h2004;
  localparam logic [15:0] OP_DUP  = 16'h3000;
  localparam logic [15:0] OP_DROP = 16'h3001;
  localparam logic [15:0] OP_HALT = 16'hF000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_OPERAND = 4'd2,
    S_RD_B    = 4'd3,
    S_RD_A    = 4'd4,
    S_EXEC    = 4'd5,
    S_HALT    = 4'd6,
    S_ERROR   = 4'd7
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [15:0]       op_q, op_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic [DATA_W-1:0] seg1_q, seg1_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;

  logic [IDX_W-1:0]  idx_sp, idx_m1, idx_m2;
  logic [DATA_W-1:0] alu_r;
  logic              fault;

  // Stack indices are taken modulo the depth, which gives the unbounded wrap for free.
  assign idx_sp = sp_q[IDX_W-1:0];
  assign idx_m1 = idx_sp - IDX_W'(1);
  assign idx_m2 = idx_sp - IDX_W'(2);

  function automatic logic [ADDR_W-1:0] stk_addr(input logic [IDX_W-1:0] idx);
    return ADDR_W'(STACK_BASE) + ADDR_W'(idx);
  endfunction

`ifdef STACK_CPU_BOUNDS_EN
  logic [1:0] need_pop;
  logic       need_push;
  always_comb begin
    need_pop  = 2'd0;
    need_push = 1'b0;
    case (rom_q[15:0])
      OP_IMM:                                need_push = 1'b1;
      OP_JZ, OP_DROP:                        need_pop  = 2'd1;
      OP_DUP: begin                          need_pop  = 2'd1; need_push = 1'b1; end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: need_pop  = 2'd2;
      default: ;
    endcase
    fault = (sp_q < SP_W'(need_pop)) || (need_push && (sp_q == SP_W'(STACK_DEPTH)));
  end
`else
  assign fault = 1'b0;
`endif

  // a arrives on ram_q at the end of EXEC; b was captured earlier in RD_A.
  always_comb begin
    case (op_q)
      OP_SUB:  alu_r = ram_q - b_q;
      OP_AND:  alu_r = ram_q & b_q;
      OP_OR:   alu_r = ram_q | b_q;
      OP_XOR:  alu_r = ram_q ^ b_q;
      default: alu_r = ram_q + b_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    op_d       = op_q;
    b_d        = b_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;
    seg1_d     = seg1_q;
    halted_d   = halted_q;
    error_d    = error_q;
    case (state_q)
      S_FETCH, S_OPERAND, S_RD_B, S_RD_A: begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == S_RD_A && cnt_q == '0) b_d = ram_q;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_RD_B: begin
              if (op_q == OP_DUP) state_d = S_EXEC;
              else begin
                state_d    = S_RD_A;
                ram_addr_d = stk_addr(idx_m2);
              end
            end
            default: state_d = S_EXEC;
          endcase
        end
      end
      S_DECODE: begin
        op_d  = rom_q[15:0];
        cnt_d = '0;
        if (fault) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          case (rom_q[15:0])
            OP_NOP: begin
              pc_d    = pc_q + 1'b1;
              state_d = S_FETCH;
            end
            OP_IMM, OP_JMP: begin
              pc_d    = pc_q + 1'b1;
              state_d = S_OPERAND;
            end
            OP_JZ: begin
              pc_d       = pc_q + 1'b1;
              state_d    = S_OPERAND;
              ram_addr_d = stk_addr(idx_m1);
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DUP: begin
              pc_d       = pc_q + 1'b1;
              state_d    = S_RD_B;
              ram_addr_d = stk_addr(idx_m1);
            end
            OP_DROP: begin
              pc_d    = pc_q + 1'b1;
              sp_d    = sp_q - 1'b1;
              state_d = S_FETCH;
            end
            OP_HALT: begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
            default: begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end
          endcase
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OP_IMM: begin
            ram_wren_d = 1'b1;
            ram_addr_d = stk_addr(idx_sp);
            ram_data_d = rom_q;
            sp_d       = sp_q + 1'b1;
            pc_d       = pc_q + 1'b1;
          end
          OP_JMP: pc_d = ADDR_W'(rom_q);
          OP_JZ: begin
            sp_d = sp_q - 1'b1;
            pc_d = (ram_q == '0) ? ADDR_W'(rom_q) : pc_q + 1'b1;
          end
          OP_DUP: begin
            ram_wren_d = 1'b1;
            ram_addr_d = stk_addr(idx_sp);
            ram_data_d = ram_q;
            seg1_d     = ram_q;
            sp_d       = sp_q + 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ram_wren_d = 1'b1;
            ram_addr_d = stk_addr(idx_m2);
            ram_data_d = alu_r;
            seg1_d     = alu_r;
            sp_d       = sp_q - 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
`ifndef STACK_CPU_BOUNDS_EN
    sp_d[SP_W-1] = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FETCH;
      cnt_q      <= '0;
      pc_q       <= '0;
      sp_q       <= '0;
      op_q       <= '0;
      b_q        <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      seg1_q     <= '0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      op_q       <= op_d;
      b_q        <= b_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      seg1_q     <= seg1_d;
      halted_q   <= halted_d;
      error_q    <= error_d;
    end
  end

  assign rom_addr  = pc_q;
  assign pc_out    = pc_q;
  assign sp_out    = ADDR_W'(sp_q);
  assign state_out = state_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  assign ram_wren  = ram_wren_q;
  assign seg1      = seg1_q;
  assign halted    = halted_q;
  assign error     = error_q;
endmodule
